numbers_hit_mux: RTL and testbench

//  Downstream stage of the multiple-numbers display. Merges the per-number drawing

---
 rtl/numbers_hit_mux.sv | 120 ++++++++++++
 tb/tb_numbers_hit_mux.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/numbers_hit_mux.sv
// numbers_hit_mux: merges the per-number drawing layer into one request/colour
// pair for the VGA object mux, and turns player-vs-number collisions into at
// most one committed hit per frame. Hit numbers are hidden until clearMask.
//
// Pulse semantics: startOfFrame, clearMask and singleHit are single-cycle,
// active-high strobes. They carry no handshake. An input strobe is acted on at
// the rising edge where it is sampled high, and singleHit is high for exactly
// the one cycle that follows a commit edge.
module numbers_hit_mux #(
    parameter int NUM_COUNT = 12,
    parameter int RGB_W     = 8,
    localparam int IDX_W    = $clog2(NUM_COUNT)
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic [NUM_COUNT-1:0]       numbersDR,
    input  logic [NUM_COUNT*RGB_W-1:0] numbersRGB,
    input  logic                       playerDR,
    input  logic                       clearMask,
    output logic                       drawingRequest,
    output logic [RGB_W-1:0]           RGBout,
    output logic                       singleHit,
    output logic [IDX_W-1:0]           hitIndex,
    output logic [NUM_COUNT-1:0]       hitMask,
    output logic                       debug_state
);

    typedef enum logic {
        ARMED   = 1'b0,
        LATCHED = 1'b1
    } state_t;

    state_t               state_q, state_n;
    logic [IDX_W-1:0]     pend_q, pend_n;
    logic [IDX_W-1:0]     idx_n;
    logic [NUM_COUNT-1:0] mask_n;
    logic                 hit_n;

    logic [NUM_COUNT-1:0] visible;
    logic [NUM_COUNT-1:0] coll;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand_idx;

    assign debug_state = state_q;

    // Hidden numbers drop out of both the picture and collision detection.
    assign visible = numbersDR & ~hitMask;
    assign coll    = visible & {NUM_COUNT{playerDR}};

    // Priority encoders: the lowest set index wins (loop runs high-to-low so
    // the last assignment is the lowest index).
    always_comb begin
        win_idx  = '0;
        cand_idx = '0;
        for (int i = NUM_COUNT - 1; i >= 0; i--) begin
            if (visible[i]) win_idx = IDX_W'(i);
            if (coll[i])    cand_idx = IDX_W'(i);
        end
    end

    // Merged number layer, one cycle behind the inputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            drawingRequest <= 1'b0;
            RGBout         <= '0;
        end else begin
            drawingRequest <= |visible;
            RGBout         <= (|visible) ? numbersRGB[win_idx*RGB_W +: RGB_W] : '0;
        end
    end

    // Hit FSM state and its registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ARMED;
            pend_q    <= '0;
            singleHit <= 1'b0;
            hitIndex  <= '0;
            hitMask   <= '0;
        end else begin
            state_q   <= state_n;
            pend_q    <= pend_n;
            singleHit <= hit_n;
            hitIndex  <= idx_n;
            hitMask   <= mask_n;
        end
    end

    // Hit FSM next state: clear beats frame start, frame start commits the
    // pending hit and may re-latch for the new frame, otherwise the first
    // collision of the frame is latched and later ones are ignored.
    always_comb begin
        state_n = state_q;
        pend_n  = pend_q;
        idx_n   = hitIndex;
        mask_n  = hitMask;
        hit_n   = 1'b0;
        if (clearMask) begin
            mask_n  = '0;
            state_n = ARMED;
            pend_n  = '0;
        end else if (startOfFrame) begin
            if (state_q == LATCHED) begin
                hit_n          = 1'b1;
                idx_n          = pend_q;
                mask_n[pend_q] = 1'b1;
                state_n        = ARMED;
            end
            if (|coll) begin
                pend_n  = cand_idx;
                state_n = LATCHED;
            end
        end else if (state_q == ARMED && (|coll)) begin
            pend_n  = cand_idx;
            state_n = LATCHED;
        end
    end

endmodule

// File: tb/tb_numbers_hit_mux.sv
// Directed bench for numbers_hit_mux: merge priority, single commit per frame,
// masking, clear priority and asynchronous reset.
module tb_numbers_hit_mux;

    localparam int NUM_COUNT = 12;
    localparam int RGB_W     = 8;
    localparam int IDX_W     = $clog2(NUM_COUNT);

    logic                       clk;
    logic                       resetN;
    logic                       startOfFrame;
    logic [NUM_COUNT-1:0]       numbersDR;
    logic [NUM_COUNT*RGB_W-1:0] numbersRGB;
    logic                       playerDR;
    logic                       clearMask;
    logic                       drawingRequest;
    logic [RGB_W-1:0]           RGBout;
    logic                       singleHit;
    logic [IDX_W-1:0]           hitIndex;
    logic [NUM_COUNT-1:0]       hitMask;
    logic                       debug_state;

    int n_checks;
    int n_errors;

    numbers_hit_mux #(
        .NUM_COUNT(NUM_COUNT),
        .RGB_W(RGB_W)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .numbersDR(numbersDR),
        .numbersRGB(numbersRGB),
        .playerDR(playerDR),
        .clearMask(clearMask),
        .drawingRequest(drawingRequest),
        .RGBout(RGBout),
        .singleHit(singleHit),
        .hitIndex(hitIndex),
        .hitMask(hitMask),
        .debug_state(debug_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic pulse_clear();
        clearMask = 1'b1;
        tick();
        clearMask = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        numbersDR    = '0;
        playerDR     = 1'b0;
        clearMask    = 1'b0;
        for (int i = 0; i < NUM_COUNT; i++)
            numbersRGB[i*RGB_W +: RGB_W] = RGB_W'(8'h40 + i);
        numbersRGB[2*RGB_W +: RGB_W] = 8'h1C;
        numbersRGB[3*RGB_W +: RGB_W] = 8'hE0;

        // reset state
        #2;
        check("rst_dr", drawingRequest, 0);
        check("rst_rgb", RGBout, 0);
        check("rst_hit", singleHit, 0);
        check("rst_idx", hitIndex, 0);
        check("rst_mask", hitMask, 0);
        check("rst_state", debug_state, 0);
        tick();
        tick();
        resetN = 1'b1;
        tick();

        // T1: merge priority and latency
        numbersDR = 12'h00C;
        tick();
        check("t1_dr", drawingRequest, 1);
        check("t1_rgb", RGBout, 8'h1C);
        numbersDR = 12'h008;
        tick();
        check("t1_rgb3", RGBout, 8'hE0);
        numbersDR = 12'h000;
        tick();
        check("t1_dr0", drawingRequest, 0);
        check("t1_rgb0", RGBout, 0);
        check("t1_state", debug_state, 0);

        // T2: first collision of the frame wins, one commit
        numbersDR = 12'h020;
        playerDR  = 1'b1;
        tick();
        check("t2_latched", debug_state, 1);
        numbersDR = 12'h080;
        tick();
        numbersDR = 12'h000;
        playerDR  = 1'b0;
        pulse_sof();
        check("t2_hit", singleHit, 1);
        check("t2_idx", hitIndex, 5);
        check("t2_mask", hitMask, 12'h020);
        check("t2_state", debug_state, 0);
        tick();
        check("t2_hit_1cyc", singleHit, 0);
        pulse_sof();
        check("t2_no_second", singleHit, 0);
        check("t2_idx_hold", hitIndex, 5);

        // T3: hidden number neither draws nor collides
        numbersDR = 12'h020;
        playerDR  = 1'b1;
        tick();
        check("t3_dr", drawingRequest, 0);
        check("t3_state", debug_state, 0);
        pulse_sof();
        check("t3_hit", singleHit, 0);
        numbersDR = 12'h000;
        playerDR  = 1'b0;
        pulse_clear();
        check("clr_mask", hitMask, 0);

        // T4: commit and re-latch on the same frame-start edge
        numbersDR = 12'h008;
        playerDR  = 1'b1;
        tick();
        numbersDR = 12'h200;
        pulse_sof();
        check("t4_hit3", singleHit, 1);
        check("t4_idx3", hitIndex, 3);
        check("t4_mask3", hitMask, 12'h008);
        check("t4_relatch", debug_state, 1);
        numbersDR = 12'h000;
        playerDR  = 1'b0;
        tick();
        check("t4_gap", singleHit, 0);
        pulse_sof();
        check("t4_hit9", singleHit, 1);
        check("t4_idx9", hitIndex, 9);
        check("t4_mask9", hitMask, 12'h208);
        numbersDR = 12'h208;
        playerDR  = 1'b1;
        tick();
        check("t4_masked_dr", drawingRequest, 0);
        check("t4_masked_state", debug_state, 0);
        numbersDR = 12'h20C;
        tick();
        check("t4_vis_rgb", RGBout, 8'h1C);
        numbersDR = 12'h000;
        playerDR  = 1'b0;
        pulse_clear();

        // T5: clear drops a pending hit, and beats a simultaneous frame start
        numbersDR = 12'h002;
        playerDR  = 1'b1;
        tick();
        check("t5_latched", debug_state, 1);
        numbersDR = 12'h000;
        playerDR  = 1'b0;
        pulse_clear();
        check("t5_state", debug_state, 0);
        pulse_sof();
        check("t5_hit", singleHit, 0);
        check("t5_mask", hitMask, 0);
        numbersDR = 12'h002;
        playerDR  = 1'b1;
        tick();
        numbersDR    = 12'h000;
        playerDR     = 1'b0;
        startOfFrame = 1'b1;
        clearMask    = 1'b1;
        tick();
        startOfFrame = 1'b0;
        clearMask    = 1'b0;
        check("t5_both_hit", singleHit, 0);
        check("t5_both_mask", hitMask, 0);
        pulse_sof();
        check("t5_after_hit", singleHit, 0);
        check("t5_idx_hold", hitIndex, 9);

        // T6: asynchronous reset discards a pending hit
        numbersDR = 12'h010;
        playerDR  = 1'b1;
        tick();
        check("t6_latched", debug_state, 1);
        check("t6_dr", drawingRequest, 1);
        #2;
        resetN = 1'b0;
        #1;
        check("t6_async_dr", drawingRequest, 0);
        check("t6_async_rgb", RGBout, 0);
        check("t6_async_idx", hitIndex, 0);
        check("t6_async_state", debug_state, 0);
        numbersDR = 12'h000;
        playerDR  = 1'b0;
        tick();
        resetN = 1'b1;
        tick();
        pulse_sof();
        check("t6_hit", singleHit, 0);
        check("t6_mask", hitMask, 0);

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
